// File: rtl/tr_link_sequencer.sv
// rtl/tr_link_sequencer.sv - transceiver bring-up/recovery sequencer (fPLL, PMA ready, PCS reset, sync)
module tr_link_sequencer #(
    parameter int                NUM_TR         = 3,
    parameter logic [NUM_TR-1:0] LANE_MASK      = 3'b011,
    parameter int                SRC_LANE       = 0,
    parameter int                PD_CYCLES      = 16,
    parameter int                LOCK_TIMEOUT   = 4096,
    parameter int                PCS_RST_CYCLES = 8,
    parameter int                SYNC_TIMEOUT   = 65536,
    parameter int                LOSS_CYCLES    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pll_locked_i,
    input  logic              pll_cal_busy_i,
    input  logic [NUM_TR-1:0] tx_rdy_i,
    input  logic [NUM_TR-1:0] rx_rdy_i,
    input  logic [NUM_TR-1:0] rx_sync_i,
    output logic              pll_powerdown_o,
    output logic [NUM_TR-1:0] pcs_tx_rst_o,
    output logic [NUM_TR-1:0] pcs_rx_rst_o,
    output logic              fifo_en_o,
    output logic              link_up_o,
    output logic [2:0]        state_o,
    output logic [7:0]        retry_cnt_o
);

    localparam int MAX_T = (LOCK_TIMEOUT > SYNC_TIMEOUT) ? LOCK_TIMEOUT : SYNC_TIMEOUT;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam int LW    = $clog2(LOSS_CYCLES + 1);
    localparam int SW    = 2 + 3 * NUM_TR;
    localparam logic [NUM_TR-1:0] SRC_SEL = NUM_TR'(1) << SRC_LANE;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_PLL_PD    = 3'd1,
        ST_PLL_WAIT  = 3'd2,
        ST_XCVR_WAIT = 3'd3,
        ST_PCS_RST   = 3'd4,
        ST_SYNC_WAIT = 3'd5,
        ST_RUN       = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     meta_q, sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     loss_q, loss_d;
    logic [7:0]        retry_q, retry_d;
    logic              pd_q, fifo_q, link_q;
    logic [NUM_TR-1:0] pcs_rst_q, pcs_rst_d;
    logic              bump;

    logic              lock_s, cal_s, sync_src;
    logic [NUM_TR-1:0] tx_s, rx_s, sy_s;
    logic              pll_ok, lanes_ok;

    assign lock_s   = sync_q[0];
    assign cal_s    = sync_q[1];
    assign tx_s     = sync_q[2 +: NUM_TR];
    assign rx_s     = sync_q[2 + NUM_TR +: NUM_TR];
    assign sy_s     = sync_q[2 + 2 * NUM_TR +: NUM_TR];
    assign sync_src = |(sy_s & SRC_SEL);
    assign pll_ok   = lock_s && !cal_s;
    // Unmasked lanes count as ready so they never gate the sequence.
    assign lanes_ok = &((tx_s & rx_s) | ~LANE_MASK);

    always_comb begin
        state_d = state_q;
        bump    = 1'b0;
        case (state_q)
            ST_RESET:  state_d = ST_PLL_PD;
            ST_PLL_PD: if (cnt_q == CW'(PD_CYCLES - 1)) state_d = ST_PLL_WAIT;
            ST_PLL_WAIT: begin
                if (pll_ok) state_d = ST_XCVR_WAIT;
                else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_PLL_PD;
                    bump    = 1'b1;
                end
            end
            ST_XCVR_WAIT: begin
                if (!pll_ok) state_d = ST_PLL_PD;
                else if (lanes_ok) state_d = ST_PCS_RST;
                else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_PLL_PD;
                    bump    = 1'b1;
                end
            end
            ST_PCS_RST: begin
                if (!pll_ok) state_d = ST_PLL_PD;
                else if (!lanes_ok) state_d = ST_XCVR_WAIT;
                else if (cnt_q == CW'(PCS_RST_CYCLES - 1)) state_d = ST_SYNC_WAIT;
            end
            ST_SYNC_WAIT: begin
                if (!pll_ok) state_d = ST_PLL_PD;
                else if (!lanes_ok) state_d = ST_XCVR_WAIT;
                else if (sync_src) state_d = ST_RUN;
                else if (cnt_q == CW'(SYNC_TIMEOUT - 1)) begin
                    state_d = ST_PCS_RST;
                    bump    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!pll_ok) state_d = ST_PLL_PD;
                else if (!lanes_ok) state_d = ST_XCVR_WAIT;
                else if (!sync_src && loss_q == LW'(LOSS_CYCLES - 1)) begin
                    state_d = ST_PCS_RST;
                    bump    = 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Dwell counter restarts on every state change and saturates while parked in RUN.
    assign cnt_d     = (state_d != state_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
    assign loss_d    = (state_q == ST_RUN && state_d == ST_RUN && !sync_src) ? loss_q + 1'b1 : '0;
    assign retry_d   = (bump && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
    assign pcs_rst_d = (state_d == ST_SYNC_WAIT || state_d == ST_RUN) ? ~LANE_MASK : '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET;
            meta_q    <= '0;
            sync_q    <= '0;
            cnt_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            pd_q      <= 1'b1;
            pcs_rst_q <= '1;
            fifo_q    <= 1'b0;
            link_q    <= 1'b0;
        end else begin
            meta_q    <= {rx_sync_i, rx_rdy_i, tx_rdy_i, pll_cal_busy_i, pll_locked_i};
            sync_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pd_q      <= (state_d == ST_RESET || state_d == ST_PLL_PD);
            pcs_rst_q <= pcs_rst_d;
            fifo_q    <= (state_d == ST_RUN);
            link_q    <= (state_d == ST_RUN);
        end
    end

    assign pll_powerdown_o = pd_q;
    assign pcs_tx_rst_o    = pcs_rst_q;
    assign pcs_rx_rst_o    = pcs_rst_q;
    assign fifo_en_o       = fifo_q;
    assign link_up_o       = link_q;
    assign state_o         = state_q;
    assign retry_cnt_o     = retry_q;

endmodule
